// File: rtl/fulladd_pkg.sv
// fulladd_pkg: shared definitions for the full-adder self-test checker.
//   state_t      : checker FSM states
//   NUM_VECTORS  : number of exhaustive {A,B,CIn} vectors
//   VEC_W        : width of the vector index
//   expected_out : reference {COut,Sum} for a given {A,B,CIn} index
package fulladd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } state_t;

    localparam int unsigned NUM_VECTORS = 8;
    localparam int unsigned VEC_W       = 3;

    // Reference full adder; idx is {A,B,CIn}, result is {COut,Sum}.
    function automatic logic [1:0] expected_out(input logic [VEC_W-1:0] idx);
        logic a;
        logic b;
        logic c;
        {a, b, c} = idx;
        return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
    endfunction

endpackage

// File: rtl/fulladd_selftest.sv
// fulladd_selftest: sequential on-chip checker for a single-bit full adder.
// Sweeps {A,B,CIn} through 0..7, holds each vector SETTLE_CYCLES cycles plus
// one check cycle, compares the adder's Sum/COut to the reference and records
// an error count and the first failing vector.
//
// Parameters:
//   SETTLE_CYCLES : cycles each vector is held before the check cycle (1..15)
// Ports:
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   start      : single-cycle run request, accepted in IDLE or DONE only
//   A, B, CIn  : registered adder operands
//   Sum, COut  : combinational adder results
//   busy       : run in progress (SETTLE or CHECK)
//   done       : run finished, held until next accepted start or reset
//   pass       : valid with done, high iff no vector mismatched
//   err_count  : number of mismatching vectors (0..8)
//   fail_valid : at least one mismatch recorded
//   fail_vec   : {A,B,CIn} of the first mismatching vector
module fulladd_selftest
    import fulladd_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       A,
    output logic       B,
    output logic       CIn,
    input  logic       Sum,
    input  logic       COut,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic       fail_valid,
    output logic [2:0] fail_vec
);

    localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [VEC_W-1:0] LAST_IDX    = VEC_W'(NUM_VECTORS - 1);

    state_t           state_q;
    logic [VEC_W-1:0] idx_q;
    logic [3:0]       cnt_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic [3:0]       err_q;
    logic             fail_valid_q;
    logic [2:0]       fail_vec_q;

    logic [1:0]       exp_out;
    logic             mismatch;

    // The operand registers are the vector index itself.
    assign {A, B, CIn} = idx_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign err_count   = err_q;
    assign fail_valid  = fail_valid_q;
    assign fail_vec    = fail_vec_q;

    assign exp_out  = expected_out(idx_q);
    assign mismatch = ({COut, Sum} != exp_out);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_q        <= '0;
            fail_valid_q <= 1'b0;
            fail_vec_q   <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q      <= ST_SETTLE;
                        idx_q        <= '0;
                        cnt_q        <= '0;
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                        pass_q       <= 1'b0;
                        err_q        <= '0;
                        fail_valid_q <= 1'b0;
                        fail_vec_q   <= '0;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        state_q <= ST_CHECK;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                ST_CHECK: begin
                    if (mismatch) begin
                        err_q <= err_q + 4'd1;
                        if (!fail_valid_q) begin
                            fail_valid_q <= 1'b1;
                            fail_vec_q   <= idx_q;
                        end
                    end
                    if (idx_q == LAST_IDX) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        // Include the final vector's result, not yet in err_q.
                        pass_q  <= (err_q == 4'd0) && !mismatch;
                    end else begin
                        state_q <= ST_SETTLE;
                        idx_q   <= idx_q + 1'b1;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fulladd_selftest.sv
// Directed bench for fulladd_selftest: one instance with SETTLE_CYCLES=2 driving
// a switchable adder model (correct / Sum stuck at 0 / COut inverted) and one
// instance with SETTLE_CYCLES=1 driving a correct adder.
module tb_fulladd_selftest;

    logic clk;
    logic rst_n;
    logic start0;
    logic start1;
    logic [1:0] mode;
    logic sel;

    logic a0, b0, c0, sum0, cout0, busy0, done0, pass0, fv0;
    logic [3:0] err0;
    logic [2:0] fvec0;
    logic a1, b1, c1, sum1, cout1, busy1, done1, pass1, fv1;
    logic [3:0] err1;
    logic [2:0] fvec1;

    logic [2:0] obs_vec;
    logic       obs_busy, obs_done, obs_pass, obs_fv;
    logic [3:0] obs_err;
    logic [2:0] obs_fvec;

    int n_assert;
    int n_fail;

    // Adder models: mode 1 = Sum stuck at 0, mode 2 = COut inverted.
    assign sum0  = (mode == 2'd1) ? 1'b0 : (a0 ^ b0 ^ c0);
    assign cout0 = ((a0 & b0) | (a0 & c0) | (b0 & c0)) ^ (mode == 2'd2);
    assign sum1  = a1 ^ b1 ^ c1;
    assign cout1 = (a1 & b1) | (a1 & c1) | (b1 & c1);

    fulladd_selftest #(.SETTLE_CYCLES(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0),
        .A(a0), .B(b0), .CIn(c0), .Sum(sum0), .COut(cout0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .fail_valid(fv0), .fail_vec(fvec0)
    );

    fulladd_selftest #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .A(a1), .B(b1), .CIn(c1), .Sum(sum1), .COut(cout1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .fail_valid(fv1), .fail_vec(fvec1)
    );

    always_comb begin
        obs_vec  = sel ? {a1, b1, c1} : {a0, b0, c0};
        obs_busy = sel ? busy1 : busy0;
        obs_done = sel ? done1 : done0;
        obs_pass = sel ? pass1 : pass0;
        obs_err  = sel ? err1 : err0;
        obs_fv   = sel ? fv1 : fv0;
        obs_fvec = sel ? fvec1 : fvec0;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel) start1 = v;
        else     start0 = v;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_vec"},   8'(obs_vec),  8'd0);
        chk({tag, "_busy"},  8'(obs_busy), 8'd0);
        chk({tag, "_done"},  8'(obs_done), 8'd0);
        chk({tag, "_pass"},  8'(obs_pass), 8'd0);
        chk({tag, "_err"},   8'(obs_err),  8'd0);
        chk({tag, "_fv"},    8'(obs_fv),   8'd0);
        chk({tag, "_fvec"},  8'(obs_fvec), 8'd0);
    endtask

    // One full run: start sampled at edge k, then 8*(s+1) edges to done.
    task automatic run(input string tag, input int s, input bit inject,
                       input logic [3:0] exp_err, input logic exp_fv,
                       input logic [2:0] exp_fvec, input logic exp_pass);
        int total;
        total = 8 * (s + 1);
        set_start(1'b1);
        tick();
        set_start(1'b0);
        // Clearing edge: vector 0 driven, results cleared.
        chk({tag, "_k_busy"}, 8'(obs_busy), 8'd1);
        chk({tag, "_k_done"}, 8'(obs_done), 8'd0);
        chk({tag, "_k_pass"}, 8'(obs_pass), 8'd0);
        chk({tag, "_k_err"},  8'(obs_err),  8'd0);
        chk({tag, "_k_fv"},   8'(obs_fv),   8'd0);
        chk({tag, "_k_fvec"}, 8'(obs_fvec), 8'd0);
        chk({tag, "_k_vec"},  8'(obs_vec),  8'd0);
        for (int e = 1; e <= total; e++) begin
            // Optional start pulse during SETTLE of vector 3; must be ignored.
            if (inject && e == 3 * (s + 1) + 1) set_start(1'b1);
            tick();
            set_start(1'b0);
            if (e < total && (e % (s + 1)) == 0) begin
                chk($sformatf("%s_vec%0d", tag, e / (s + 1)), 8'(obs_vec), 8'(e / (s + 1)));
            end
            if (e == total - 1) begin
                chk({tag, "_predone_busy"}, 8'(obs_busy), 8'd1);
                chk({tag, "_predone_done"}, 8'(obs_done), 8'd0);
            end
        end
        chk({tag, "_done"}, 8'(obs_done), 8'd1);
        chk({tag, "_busy"}, 8'(obs_busy), 8'd0);
        chk({tag, "_err"},  8'(obs_err),  8'(exp_err));
        chk({tag, "_fv"},   8'(obs_fv),   8'(exp_fv));
        chk({tag, "_fvec"}, 8'(obs_fvec), 8'(exp_fvec));
        chk({tag, "_pass"}, 8'(obs_pass), 8'(exp_pass));
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        start0   = 1'b0;
        start1   = 1'b0;
        mode     = 2'd0;
        sel      = 1'b0;

        repeat (2) tick();
        chk_all_zero("rst0");
        sel = 1'b1;
        #1;
        chk_all_zero("rst1");
        sel = 1'b0;
        rst_n = 1'b1;
        repeat (3) tick();
        chk("idle_busy", 8'(obs_busy), 8'd0);
        chk("idle_done", 8'(obs_done), 8'd0);

        // Correct adder, stray start during vector 3 settle.
        mode = 2'd0;
        run("good_s2", 2, 1'b1, 4'd0, 1'b0, 3'd0, 1'b1);
        repeat (2) tick();
        chk("hold_done", 8'(obs_done), 8'd1);
        chk("hold_pass", 8'(obs_pass), 8'd1);

        // Sum stuck at 0: idx 1,2,4,7 fail.
        mode = 2'd1;
        run("sum0", 2, 1'b0, 4'd4, 1'b1, 3'd1, 1'b0);

        // COut inverted: every vector fails; also exercises clearing from DONE.
        mode = 2'd2;
        run("coutinv", 2, 1'b0, 4'd8, 1'b1, 3'd0, 1'b0);

        // Reset in the middle of vector 5 with errors already recorded.
        mode = 2'd1;
        set_start(1'b1);
        tick();
        set_start(1'b0);
        repeat (15) tick();
        chk("mid_vec",  8'(obs_vec),  8'd5);
        chk("mid_err",  8'(obs_err),  8'd3);
        chk("mid_fv",   8'(obs_fv),   8'd1);
        chk("mid_fvec", 8'(obs_fvec), 8'd1);
        chk("mid_busy", 8'(obs_busy), 8'd1);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        chk_all_zero("post_rst");
        mode = 2'd0;

        // SETTLE_CYCLES=1 instance, correct adder: done after 16 edges.
        sel = 1'b1;
        run("good_s1", 1, 1'b0, 4'd0, 1'b0, 3'd0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
